// File: rtl/led_bar_pkg.sv
// Shared types and helpers for the LED bar meter: display modes, peak FSM states
// and the width needed to hold a level in 0..N.
package led_bar_pkg;

  typedef enum logic {
    MODE_FILL = 1'b0,
    MODE_DOT  = 1'b1
  } disp_mode_e;

  typedef enum logic [1:0] {
    PK_IDLE  = 2'd0,
    PK_HOLD  = 2'd1,
    PK_DECAY = 2'd2
  } peak_state_e;

  function automatic int lvl_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/led_bar_decode.sv
// Combinational level-to-pattern mapping: FILL lights bits [level-1:0],
// DOT lights only bit level-1; level 0 is dark in both.
module led_bar_decode
  import led_bar_pkg::*;
#(
  parameter int N_LEDS = 10,
  parameter int LW     = lvl_width(N_LEDS)
) (
  input  logic [LW-1:0]     level_i,
  input  logic              mode_i,
  output logic [N_LEDS-1:0] pattern_o
);

  always_comb begin
    pattern_o = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (mode_i == MODE_DOT) pattern_o[i] = (LW'(i + 1) == level_i);
      else                    pattern_o[i] = (LW'(i) < level_i);
    end
  end

endmodule

// File: rtl/led_bar_meter.sv
// LED bar meter with optional peak hold/decay (macro LED_BAR_PEAK_EN).
// leds, over and peak are registered; state_dbg exposes the peak FSM state.
module led_bar_meter
  import led_bar_pkg::*;
#(
  parameter int N_LEDS    = 10,
  parameter int SEL_W     = 4,
  parameter int HOLD_CYC  = 25000000,
  parameter int DECAY_CYC = 2500000
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         load,
  input  logic                         mode,
  output logic [N_LEDS-1:0]            leds,
  output logic                         over,
  output logic [lvl_width(N_LEDS)-1:0] peak,
  output logic [1:0]                   state_dbg
);

  localparam int          LW  = lvl_width(N_LEDS);
  localparam logic [31:0] N_U = 32'(N_LEDS);

  logic [31:0]       sel_ext;
  logic              sel_over;
  logic [LW-1:0]     sel_sat;
  logic [LW-1:0]     level_q, level_d;
  logic              over_q, over_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic [N_LEDS-1:0] bar_pat;

  assign sel_ext  = 32'(sel);
  assign sel_over = (sel_ext > N_U);
  assign sel_sat  = sel_over ? LW'(N_LEDS) : LW'(sel_ext);
  assign level_d  = load ? sel_sat : level_q;
  assign over_d   = load ? sel_over : over_q;

  // Decoding the next level (not level_q) keeps leds one register behind sel.
  led_bar_decode #(.N_LEDS(N_LEDS), .LW(LW)) u_bar (
    .level_i  (level_d),
    .mode_i   (mode),
    .pattern_o(bar_pat)
  );

`ifdef LED_BAR_PEAK_EN
  localparam int          MAXC    = (HOLD_CYC > DECAY_CYC) ? HOLD_CYC : DECAY_CYC;
  localparam int          CW      = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] DECAY_LD = CW'(DECAY_CYC - 1);

  peak_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     peak_q, peak_d;
  logic [N_LEDS-1:0] peak_pat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    // A qualifying load wins over any counter expiry in the same cycle.
    if (load && (sel_sat >= peak_q)) begin
      if (sel_sat == '0) begin
        state_d = PK_IDLE;
        cnt_d   = '0;
      end else begin
        peak_d  = sel_sat;
        cnt_d   = HOLD_LD;
        state_d = PK_HOLD;
      end
    end else begin
      case (state_q)
        PK_HOLD: begin
          if (cnt_q == '0) begin
            state_d = PK_DECAY;
            cnt_d   = DECAY_LD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        PK_DECAY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if ((peak_q - LW'(1)) <= level_d) begin
            // Peak has caught up with the live level: park on it.
            peak_d = level_d;
            if (level_d == '0) begin
              state_d = PK_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = PK_HOLD;
              cnt_d   = HOLD_LD;
            end
          end else begin
            peak_d = peak_q - LW'(1);
            cnt_d  = DECAY_LD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= PK_IDLE;
      cnt_q   <= '0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
    end
  end

  led_bar_decode #(.N_LEDS(N_LEDS), .LW(LW)) u_peak (
    .level_i  (peak_d),
    .mode_i   (MODE_DOT),
    .pattern_o(peak_pat)
  );

  assign leds_d    = bar_pat | peak_pat;
  assign peak      = peak_q;
  assign state_dbg = state_q;
`else
  localparam int unused_timing = HOLD_CYC + DECAY_CYC;

  assign leds_d    = bar_pat;
  assign peak      = '0;
  assign state_dbg = PK_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      level_q <= '0;
      over_q  <= 1'b0;
      leds_q  <= '0;
    end else begin
      level_q <= level_d;
      over_q  <= over_d;
      leds_q  <= leds_d;
    end
  end

  assign leds = leds_q;
  assign over = over_q;

endmodule

// File: tb/tb_led_bar_meter.sv
// Bench for led_bar_meter (N_LEDS=10, HOLD=4, DECAY=2): vector table, hand
// sequences for peak corner cases, then random stimulus against a timeline model.
module tb_led_bar_meter;
  import led_bar_pkg::*;

  localparam int N      = 10;
  localparam int HOLD_T = 4;
  localparam int DECAY_T = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] sel = '0;
  logic       load = 1'b0;
  logic       mode = 1'b0;
  logic [9:0] leds;
  logic       over;
  logic [3:0] peak;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // Model: peak is set at an "anchor" edge; decrements happen at
  // anchor + HOLD + k*DECAY (k >= 1) until it meets the current level.
  int         m_level, m_peak, m_anchor, m_n;
  logic       m_over;
  logic [9:0] m_leds;
  logic [1:0] m_state;

  always #5 clk = ~clk;

  led_bar_meter #(.N_LEDS(N), .SEL_W(4), .HOLD_CYC(HOLD_T), .DECAY_CYC(DECAY_T)) dut (
    .clk(clk), .clr(clr), .sel(sel), .load(load), .mode(mode),
    .leds(leds), .over(over), .peak(peak), .state_dbg(state_dbg)
  );

  function automatic logic [9:0] fill_pat(input int l);
    return 10'((1 << l) - 1);
  endfunction

  function automatic logic [9:0] dot_pat(input int l);
    return (l == 0) ? 10'h000 : 10'(1 << (l - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic c, input logic ld, input int s, input logic md);
    if (c) begin
      m_level = 0; m_over = 1'b0; m_peak = 0; m_leds = '0;
    end else begin
      if (ld) begin
        m_level = (s > N) ? N : s;
        m_over  = (s > N);
      end
`ifdef LED_BAR_PEAK_EN
      if (ld && m_level >= m_peak && m_level > 0) begin
        m_peak = m_level; m_anchor = m_n;
      end else if (m_peak > 0 && (m_n - m_anchor) > HOLD_T &&
                   ((m_n - m_anchor - HOLD_T) % DECAY_T) == 0) begin
        if (m_peak - 1 <= m_level) begin
          m_peak = m_level; m_anchor = m_n;
        end else begin
          m_peak = m_peak - 1;
        end
      end
`endif
      m_leds = (md ? dot_pat(m_level) : fill_pat(m_level)) | dot_pat(m_peak);
    end
    if (m_peak == 0)                   m_state = PK_IDLE;
    else if (m_n - m_anchor < HOLD_T)  m_state = PK_HOLD;
    else                               m_state = PK_DECAY;
    m_n++;
  endtask

  task automatic step(input logic c, input logic ld, input int s, input logic md);
    clr = c; load = ld; sel = 4'(s); mode = md;
    @(posedge clk);
    #1;
    model_edge(c, ld, s, md);
    chk("leds", 32'(leds), 32'(m_leds));
    chk("over", 32'(over), 32'(m_over));
    chk("peak", 32'(peak), 32'(m_peak));
    chk("state", 32'(state_dbg), 32'(m_state));
  endtask

  typedef struct {
    int         s;
    logic [9:0] exp_leds;
    logic       exp_over;
  } vec_t;

  vec_t tbl[16];
  int   exp_pk[18];
  logic [9:0] exp_hold_leds;

  initial begin
    m_level = 0; m_peak = 0; m_anchor = 0; m_n = 0; m_over = 1'b0;
    m_leds = '0; m_state = PK_IDLE;

    for (int i = 0; i < 16; i++) begin
      tbl[i].s        = i;
      tbl[i].exp_leds = fill_pat((i > N) ? N : i);
      tbl[i].exp_over = (i > N);
    end
`ifdef LED_BAR_PEAK_EN
    exp_pk = '{8, 8, 8, 8, 8, 8, 7, 7, 6, 6, 5, 5, 4, 4, 3, 3, 2, 2};
    exp_hold_leds = 10'h083;
`else
    exp_pk = '{default: 0};
    exp_hold_leds = 10'h003;
`endif

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 9, 0);
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_peak", 32'(peak), 32'h0);

    // FILL sweep
    for (int i = 0; i < 16; i++) begin
      step(0, 1, tbl[i].s, 0);
      chk("sweep_leds", 32'(leds), 32'(tbl[i].exp_leds));
      chk("sweep_over", 32'(over), 32'(tbl[i].exp_over));
    end

    // DOT mode
    step(1, 0, 0, 1);
    step(0, 1, 7, 1);
    chk("dot7_leds", 32'(leds), 32'h040);
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    chk("dot0_leds", 32'(leds), 32'h000);

    // Hold then decay to the live level
    step(1, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      if (k == 0)      step(0, 1, 8, 0);
      else if (k == 1) step(0, 1, 2, 0);
      else             step(0, 0, 15, 0);
      chk("hd_peak", 32'(peak), 32'(exp_pk[k]));
      if (k >= 1 && k <= 4) chk("hd_leds", 32'(leds), 32'(exp_hold_leds));
`ifdef LED_BAR_PEAK_EN
      if (k == 16) chk("hd_rehold", 32'(state_dbg), 32'(PK_HOLD));
`endif
    end

    // Load coinciding with a decay expiry
    step(1, 0, 0, 0);
    step(0, 1, 8, 0);
    step(0, 1, 2, 0);
    for (int k = 2; k < 6; k++) step(0, 0, 0, 0);
    step(0, 1, 9, 0);
`ifdef LED_BAR_PEAK_EN
    chk("simul_peak", 32'(peak), 32'd9);
    chk("simul_state", 32'(state_dbg), 32'(PK_HOLD));
`else
    chk("simul_peak", 32'(peak), 32'd0);
`endif
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);

    // Reset mid-DECAY overrides load, then load honoured right away
    step(1, 0, 0, 0);
    step(0, 1, 12, 0);
    for (int k = 1; k < 7; k++) step(0, 0, 0, 0);
    step(1, 1, 5, 0);
    chk("clr_leds", 32'(leds), 32'h0);
    chk("clr_peak", 32'(peak), 32'h0);
    chk("clr_over", 32'(over), 32'h0);
    chk("clr_state", 32'(state_dbg), 32'(PK_IDLE));
    step(0, 1, 3, 0);
    chk("post_clr_leds", 32'(leds), 32'h007);

    // Random traffic with long idle stretches so decay gets exercised
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(63, 0) == 0), ($urandom_range(5, 0) == 0),
           int'($urandom_range(15, 0)), ($urandom_range(3, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
